// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FSTATE_IDLE = 2'd0,
    FSTATE_WAIT = 2'd1,
    FSTATE_HOLD = 2'd2
  } fstate_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // IM is word addressed; low PC bits never reach the bus.
  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the F-stage PC, drives the IM request handshake and
// buffers a fetched word while D is stalled.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] next_PC,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_adel,
  output logic [31:0] fetch_cnt
);

  fstate_e     state;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic [31:0] cnt_q;

  logic        misaligned;
  logic [31:0] raw_instr;

  assign im_req     = (state == FSTATE_WAIT);
  assign im_addr    = word_addr(pc_q);
  assign F_PC       = pc_q;
  assign fetch_cnt  = cnt_q;
  assign misaligned = (pc_q[1:0] != 2'b00);

  // WAIT forwards the IM word straight through; HOLD replays the buffered copy.
  assign F_valid   = (state == FSTATE_HOLD) || (im_req && im_ready);
  assign raw_instr = (state == FSTATE_HOLD) ? buf_q : im_rdata;
  assign F_adel    = F_valid && misaligned;
  assign F_instr   = (F_valid && !misaligned) ? raw_instr : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FSTATE_IDLE;
      pc_q  <= RESET_PC;
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        FSTATE_IDLE: state <= FSTATE_WAIT;
        FSTATE_WAIT: begin
          if (im_ready) begin
            if (!stall) begin
              pc_q  <= next_PC;
              cnt_q <= cnt_q + 32'd1;
            end else begin
              buf_q <= im_rdata;
              state <= FSTATE_HOLD;
            end
          end
        end
        FSTATE_HOLD: begin
          if (!stall) begin
            pc_q  <= next_PC;
            cnt_q <= cnt_q + 32'd1;
            state <= FSTATE_WAIT;
          end
        end
        default: state <= FSTATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a per-cycle vector table plus hand-written
// reset/wrap sequences.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, im_ready;
  logic [31:0] next_PC, im_rdata;
  logic        im_req, F_valid, F_adel;
  logic [31:0] im_addr, F_PC, F_instr, fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .next_PC(next_PC),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
    .F_PC(F_PC), .F_instr(F_instr), .F_valid(F_valid), .F_adel(F_adel),
    .fetch_cnt(fetch_cnt)
  );

  typedef struct {
    logic        rst, stl, rdy;
    logic [31:0] rdata, npc;
    logic        ereq;
    logic [31:0] eaddr, epc, einstr;
    logic        evld, eadel;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, stl, rdy, input logic [31:0] rdata, npc,
                     input logic ereq, input logic [31:0] eaddr, epc, einstr,
                     input logic evld, eadel, input logic [31:0] ecnt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdy = rdy; v.rdata = rdata; v.npc = npc;
    v.ereq = ereq; v.eaddr = eaddr; v.epc = epc; v.einstr = einstr;
    v.evld = evld; v.eadel = eadel; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  // Drive at posedge+1, leave the caller at the following negedge to sample.
  task automatic drive(input logic rst, stl, rdy, input logic [31:0] rdata, npc);
    reset = rst; stall = stl; im_ready = rdy; im_rdata = rdata; next_PC = npc;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [130:0] act, exp;
    //   rst stl rdy rdata          npc            req addr           F_PC           instr          vld adel cnt
    // reset cycle: stray im_ready ignored
    add(0, 0, 1, 32'h1111_1111, 32'h0000_3004, 0, 32'h0000_3000, 32'h0000_3000, 32'h0, 0, 0, 0);
    // IDLE after release: no request yet
    add(1, 0, 1, 32'hAAAA_0000, 32'h0000_3004, 0, 32'h0000_3000, 32'h0000_3000, 32'h0, 0, 0, 0);
    // back-to-back fetches, one per cycle
    add(1, 0, 1, 32'hA000_0000, 32'h0000_3004, 1, 32'h0000_3000, 32'h0000_3000, 32'hA000_0000, 1, 0, 0);
    add(1, 0, 1, 32'hA000_0001, 32'h0000_3008, 1, 32'h0000_3004, 32'h0000_3004, 32'hA000_0001, 1, 0, 1);
    add(1, 0, 1, 32'hA000_0002, 32'h0000_300C, 1, 32'h0000_3008, 32'h0000_3008, 32'hA000_0002, 1, 0, 2);
    add(1, 0, 1, 32'hA000_0003, 32'h0000_3010, 1, 32'h0000_300C, 32'h0000_300C, 32'hA000_0003, 1, 0, 3);
    // IM late by 3 cycles at 3010: address held, bubbles, junk next_PC ignored
    add(1, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 32'h0000_3010, 32'h0000_3010, 32'h0, 0, 0, 4);
    add(1, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 32'h0000_3010, 32'h0000_3010, 32'h0, 0, 0, 4);
    add(1, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 32'h0000_3010, 32'h0000_3010, 32'h0, 0, 0, 4);
    add(1, 0, 1, 32'hB000_0000, 32'h0000_3014, 1, 32'h0000_3010, 32'h0000_3010, 32'hB000_0000, 1, 0, 4);
    // response with stall: capture, then hold 3 more stalled cycles, then accept
    add(1, 1, 1, 32'h2408_0001, 32'hDEAD_BEEF, 1, 32'h0000_3014, 32'h0000_3014, 32'h2408_0001, 1, 0, 5);
    add(1, 1, 1, 32'h5555_5555, 32'hDEAD_BEEF, 0, 32'h0000_3014, 32'h0000_3014, 32'h2408_0001, 1, 0, 5);
    add(1, 1, 1, 32'h5555_5555, 32'hDEAD_BEEF, 0, 32'h0000_3014, 32'h0000_3014, 32'h2408_0001, 1, 0, 5);
    add(1, 1, 0, 32'h5555_5555, 32'hDEAD_BEEF, 0, 32'h0000_3014, 32'h0000_3014, 32'h2408_0001, 1, 0, 5);
    add(1, 0, 0, 32'h5555_5555, 32'h0000_3018, 0, 32'h0000_3014, 32'h0000_3014, 32'h2408_0001, 1, 0, 5);
    // branch at 3018, delay slot 301C, target 3040
    add(1, 0, 1, 32'hC000_0000, 32'h0000_301C, 1, 32'h0000_3018, 32'h0000_3018, 32'hC000_0000, 1, 0, 6);
    add(1, 0, 1, 32'hC000_0001, 32'h0000_3040, 1, 32'h0000_301C, 32'h0000_301C, 32'hC000_0001, 1, 0, 7);
    add(1, 0, 1, 32'hC000_0002, 32'h0000_3042, 1, 32'h0000_3040, 32'h0000_3040, 32'hC000_0002, 1, 0, 8);
    // misaligned 3042: aligned request, AdEL, nop; next aligned PC clears it
    add(1, 0, 1, 32'hC000_0003, 32'h0000_3048, 1, 32'h0000_3040, 32'h0000_3042, 32'h0, 1, 1, 9);
    add(1, 0, 0, 32'hC000_0004, 32'h0000_304C, 1, 32'h0000_3048, 32'h0000_3048, 32'h0, 0, 0, 10);
    add(1, 0, 1, 32'hC000_0004, 32'h0000_304C, 1, 32'h0000_3048, 32'h0000_3048, 32'hC000_0004, 1, 0, 10);

    reset = 1'b0; stall = 1'b0; im_ready = 1'b0; im_rdata = '0; next_PC = '0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].rdy, vecs[i].rdata, vecs[i].npc);
      act = {im_req, im_addr, F_PC, F_instr, F_valid, F_adel, fetch_cnt};
      exp = {vecs[i].ereq, vecs[i].eaddr, vecs[i].epc, vecs[i].einstr,
             vecs[i].evld, vecs[i].eadel, vecs[i].ecnt};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL vec%0d {req,addr,pc,instr,vld,adel,cnt}: got %h expected %h", i, act, exp);
      end
      advance();
    end

    // Now WAIT at 304C, cnt=11. Capture into HOLD, then reset while holding.
    drive(1, 1, 1, 32'hD000_0000, 32'hDEAD_BEEF);
    chk("hold_capture_instr", F_instr, 32'hD000_0000);
    advance();
    drive(0, 1, 0, 32'h0, 32'hDEAD_BEEF);
    chk("hold_pre_reset_req", {31'd0, im_req}, 32'd0);
    chk("hold_pre_reset_cnt", fetch_cnt, 32'd11);
    advance();
    drive(1, 0, 1, 32'hEEEE_EEEE, 32'h0000_3004);
    chk("rst_hold_valid", {31'd0, F_valid}, 32'd0);
    chk("rst_hold_req", {31'd0, im_req}, 32'd0);
    chk("rst_hold_pc", F_PC, 32'h0000_3000);
    chk("rst_hold_cnt", fetch_cnt, 32'd0);
    chk("rst_hold_instr", F_instr, 32'd0);
    advance();
    // Request pending, then reset arrives together with the response.
    drive(1, 0, 0, 32'h0, 32'h0000_3004);
    chk("pend_req", {31'd0, im_req}, 32'd1);
    chk("pend_addr", im_addr, 32'h0000_3000);
    advance();
    drive(0, 0, 1, 32'h7777_7777, 32'h0000_3004);
    advance();
    drive(1, 0, 1, 32'h7777_7777, 32'h0000_3004);
    chk("rst_pend_valid", {31'd0, F_valid}, 32'd0);
    chk("rst_pend_req", {31'd0, im_req}, 32'd0);
    chk("rst_pend_cnt", fetch_cnt, 32'd0);
    chk("rst_pend_pc", F_PC, 32'h0000_3000);
    advance();
    // Counter wrap: preload just below all-ones.
    dut.cnt_q = 32'hFFFF_FFFE;
    drive(1, 0, 1, 32'hF000_0000, 32'h0000_3004);
    chk("wrap_pre_cnt", fetch_cnt, 32'hFFFF_FFFE);
    chk("wrap_pre_instr", F_instr, 32'hF000_0000);
    advance();
    drive(1, 0, 1, 32'hF000_0001, 32'h0000_3008);
    chk("wrap_max_cnt", fetch_cnt, 32'hFFFF_FFFF);
    advance();
    drive(1, 0, 0, 32'h0, 32'h0);
    chk("wrap_zero_cnt", fetch_cnt, 32'd0);
    chk("wrap_pc", F_PC, 32'h0000_3008);
    advance();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
